data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
- Data-memory responder for the core's load/store path: receives the memory requests the control path issues for LOAD/STORE and returns load data.
- Holds a word-organised RAM with byte-lane writes. Sign- or zero-extends byte, half and word loads.
- Loads take two cycles, matching the core's two-phase load sequencing: request phase, then data/write-back phase. Stores complete in one cycle.
- Sits between the core's address path (ALU result) and the rd write-back mux (memory input).

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W 32-bit words.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data; valid bits right-aligned
- busy  output  1  high while a load is in its data phase; requests are ignored while busy
- rsp_valid  output  1  one-cycle pulse with load data
- rsp_rdata  output  32  extended load data, valid when rsp_valid = 1
- err  output  1  misaligned-access pulse; only driven when MISALIGN_TRAP_EN is defined, else tied to 0

Behaviour:
- Word index = req_addr[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo the RAM size. The byte lane is req_addr[1:0], little-endian.
- Accept condition: req_valid && !busy.
- FSM states:
  - IDLE: on an accepted load, register the word read, size, unsigned flag and addr[1:0]; go to LOAD_RSP. On an accepted store, write the RAM at this edge and stay in IDLE.
  - LOAD_RSP: busy = 1, rsp_valid = 1, rsp_rdata = extended lane data; go to IDLE at the next edge unconditionally. A request present during LOAD_RSP is ignored; this absorbs the core repeating the LOAD opcode in its second phase.
- Latency: load accepted in cycle N gives rsp_valid in cycle N+1. No back-to-back load acceptance, so the next load is accepted no earlier than N+2. A store is written at the accepting edge; a load accepted in the next cycle sees the new data.
- Store lanes:
  - Byte: writes lane addr[1:0] with wdata[7:0].
  - Half: writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word: writes all four lanes.
  - Unwritten lanes are preserved.
- Load extraction:
  - Byte: lane shifted to [7:0].
  - Half: halfword at addr[1] shifted to [15:0].
  - Word: whole word.
  - Extension: bit 7 or bit 15 replicated unless req_unsigned = 1, which fills with zeros.
- Reset: state to IDLE; busy = 0, rsp_valid = 0, rsp_rdata = 0, err = 0. RAM contents are not cleared. Reset during LOAD_RSP aborts the response: the next cycle has rsp_valid = 0.
- Outputs are registered: rsp_valid, rsp_rdata, busy and err all come from flops.
- rsp_rdata holds its last value after rsp_valid drops; it is cleared only by reset.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, is misaligned.
  - Misaligned store: no RAM write, err pulses for 1 cycle in the next cycle.
  - Misaligned load: goes to LOAD_RSP as normal, with rsp_valid = 1, rsp_rdata = 0 and err = 1 in that cycle.
- Not defined: misaligned addresses are force-aligned by clearing addr[0] for half and addr[1:0] for word. err is constant 0.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10, then load word from 0x10 -> rsp_valid exactly one cycle after load acceptance, rsp_rdata = 0xDEADBEEF, busy high only in that cycle.
- Store byte 0x80 at 0x11 over word 0x00000000, then load byte signed at 0x11 -> 0xFFFFFF80; load byte unsigned at 0x11 -> 0x00000080; load word at 0x10 -> 0x00008000.
- Store half 0xABCD at 0x22, load half signed at 0x22 -> 0xFFFFABCD; load word at 0x20 -> upper half 0xABCD, lower half unchanged.
- Hold req_valid with a load to 0x10 for 2 consecutive cycles -> exactly one rsp_valid pulse; second cycle ignored because busy = 1.
- Assert rst in the LOAD_RSP cycle -> next cycle rsp_valid = 0, busy = 0, rsp_rdata = 0; RAM at 0x10 still reads 0xDEADBEEF afterwards.
- Address wrap and misalignment: store word 0x12345678 at 0x10 + 4*2**ADDR_W, then load word at 0x10 -> 0x12345678. With MISALIGN_TRAP_EN, a word store at 0x13 -> err pulse and RAM unchanged. Without it, the same store writes word 0x10.

Source files
------------

// File: rtl/data_mem_resp.sv
// data_mem_resp: data-memory responder for the core's load/store path.
// Word-organised RAM with byte-lane stores; loads answer one cycle after
// acceptance with sign/zero-extended byte, half or word data.
// Optional macro MISALIGN_TRAP_EN: flag misaligned half/word accesses on err
// instead of silently force-aligning them.
module data_mem_resp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE,
    LOAD_RSP
  } state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              misalign;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] load_ext;
  logic [3:0]        wr_be;
  logic [DATA_W-1:0] wr_lanes;
  logic              mem_we;

  // Address bits above the RAM are ignored so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Address decode, lane selection, load extraction and store strobes
  always_comb begin
    accept   = req_valid && !busy_q;
    word_idx = req_addr[ADDR_W+1:2];

    // Lane after force-alignment; with trapping enabled a misaligned access
    // never uses the lane, so the same selection serves both builds.
    unique case (req_size)
      2'b00:   lane = req_addr[1:0];
      2'b01:   lane = {req_addr[1], 1'b0};
      default: lane = 2'b00;
    endcase

`ifdef MISALIGN_TRAP_EN
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif

    rd_word  = mem_q[word_idx];
    rd_shift = rd_word >> {lane, 3'b000};

    unique case (req_size)
      2'b00:   load_ext = {{24{!req_unsigned && rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   load_ext = {{16{!req_unsigned && rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase

    unique case (req_size)
      2'b00: begin
        wr_be    = 4'b0001 << lane;
        wr_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be    = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        wr_be    = 4'b1111;
        wr_lanes = req_wdata;
      end
    endcase

    mem_we = accept && req_we && !misalign;
  end

  // Next-state and registered-output logic for the load response FSM
  always_comb begin
    state_d     = state_q;
    busy_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_we) begin
            err_d = misalign;
          end else begin
            state_d     = LOAD_RSP;
            busy_d      = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = misalign ? '0 : load_ext;
            err_d       = misalign;
          end
        end
      end
      LOAD_RSP: begin
        // Requests here are dropped: the core repeats the LOAD opcode in its
        // second phase and that repeat must not start another load.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem_q[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
      end
    end
  end

  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench for data_mem_resp (ADDR_W = 10).
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;

  int unsigned n_checks = 0;
  int unsigned n_passed = 0;

  data_mem_resp #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Store, then confirm the err pulse (or its absence) and that no response fires.
  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic err_exp);
    drive(1'b1, 1'b1, sz, 1'b0, a, wd);
    tick();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check({tag, ".err"}, {31'b0, err}, {31'b0, err_exp});
    check({tag, ".noresp"}, {31'b0, rsp_valid}, 32'h0);
    tick();
    check({tag, ".err_end"}, {31'b0, err}, 32'h0);
  endtask

  // Load: response exactly in the cycle after acceptance, gone the cycle after.
  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] exp, input logic err_exp);
    drive(1'b1, 1'b0, sz, uns, a, 32'h0);
    tick();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check({tag, ".valid"}, {31'b0, rsp_valid}, 32'h1);
    check({tag, ".busy"},  {31'b0, busy}, 32'h1);
    check({tag, ".rdata"}, rsp_rdata, exp);
    check({tag, ".err"},   {31'b0, err}, {31'b0, err_exp});
    tick();
    check({tag, ".valid_end"}, {31'b0, rsp_valid}, 32'h0);
    check({tag, ".busy_end"},  {31'b0, busy}, 32'h0);
    check({tag, ".hold"},      rsp_rdata, exp);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst.valid", {31'b0, rsp_valid}, 32'h0);
    check("rst.busy",  {31'b0, busy}, 32'h0);
    check("rst.rdata", rsp_rdata, 32'h0);
    check("rst.err",   {31'b0, err}, 32'h0);
    rst = 1'b0;
    tick();

    // Word store/load round trip
    do_store("st_w10", 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
    do_load ("ld_w10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

    // Byte store into a zero word, signed/unsigned byte loads, word view
    do_store("st_zero", 2'b10, 32'h10, 32'h0, 1'b0);
    do_store("st_b11",  2'b00, 32'h11, 32'hFFFFFF80, 1'b0);
    do_load ("ld_bs11", 2'b00, 1'b0, 32'h11, 32'hFFFFFF80, 1'b0);
    do_load ("ld_bu11", 2'b00, 1'b1, 32'h11, 32'h00000080, 1'b0);
    do_load ("ld_w10b", 2'b10, 1'b0, 32'h10, 32'h00008000, 1'b0);
    do_load ("ld_bu10", 2'b00, 1'b1, 32'h10, 32'h00000000, 1'b0);

    // Half store at upper half preserves lower half
    do_store("st_w20", 2'b10, 32'h20, 32'h11112222, 1'b0);
    do_store("st_h22", 2'b01, 32'h22, 32'h0000ABCD, 1'b0);
    do_load ("ld_hs22", 2'b01, 1'b0, 32'h22, 32'hFFFFABCD, 1'b0);
    do_load ("ld_hu22", 2'b01, 1'b1, 32'h22, 32'h0000ABCD, 1'b0);
    do_load ("ld_w20",  2'b10, 1'b0, 32'h20, 32'hABCD2222, 1'b0);
    do_load ("ld_hs20", 2'b01, 1'b0, 32'h20, 32'h00002222, 1'b0);
    do_load ("ld_sz3",  2'b11, 1'b0, 32'h20, 32'hABCD2222, 1'b0);

    // Load request held for two cycles produces one response
    do_store("st_w10r", 2'b10, 32'h10, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tick();
    check("hold.valid1", {31'b0, rsp_valid}, 32'h1);
    check("hold.busy1",  {31'b0, busy}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check("hold.valid2", {31'b0, rsp_valid}, 32'h0);
    check("hold.busy2",  {31'b0, busy}, 32'h0);
    tick();
    check("hold.valid3", {31'b0, rsp_valid}, 32'h0);

    // Reset during LOAD_RSP aborts the response, RAM survives
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    tick();
    check("rstl.valid_pre", {31'b0, rsp_valid}, 32'h1);
    check("rstl.rdata_pre", rsp_rdata, 32'hABCD2222);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstl.valid", {31'b0, rsp_valid}, 32'h0);
    check("rstl.busy",  {31'b0, busy}, 32'h0);
    check("rstl.rdata", rsp_rdata, 32'h0);
    tick();
    do_load("rstl.ram", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

    // Address wrap: 0x10 + 4*1024 aliases word 0x10
    do_store("st_wrap", 2'b10, 32'h00001010, 32'h12345678, 1'b0);
    do_load ("ld_wrap", 2'b10, 1'b0, 32'h10, 32'h12345678, 1'b0);
    do_load ("ld_b12",  2'b00, 1'b1, 32'h80001012, 32'h00000034, 1'b0);

    // Misaligned word store and load at 0x13
`ifdef MISALIGN_TRAP_EN
    do_store("st_mis",  2'b10, 32'h13, 32'hCAFEF00D, 1'b1);
    do_load ("ld_mis0", 2'b10, 1'b0, 32'h10, 32'h12345678, 1'b0);
    do_load ("ld_mis",  2'b10, 1'b0, 32'h13, 32'h00000000, 1'b1);
    do_load ("ld_hmis", 2'b01, 1'b0, 32'h11, 32'h00000000, 1'b1);
`else
    do_store("st_mis",  2'b10, 32'h13, 32'hCAFEF00D, 1'b0);
    do_load ("ld_mis0", 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0);
    do_load ("ld_mis",  2'b10, 1'b0, 32'h13, 32'hCAFEF00D, 1'b0);
    do_load ("ld_hmis", 2'b01, 1'b0, 32'h13, 32'hFFFFCAFE, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
